// File: rtl/alarm_cond_pkg.sv
// Shared constants and FSM state type for the alarm switch conditioning blocks.
package alarm_cond_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned GLITCH_W_DEF        = 8;

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } sw_state_t;

endpackage

// File: rtl/alarm_sync_2ff.sv
// Two-flop synchroniser for asynchronous alarm inputs; both stages reset to 0.
module alarm_sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alarm_switch_conditioner.sv
// Debounces the alarm switch pin and emits edge strobes.
// Define ALARM_SW_GLITCH_CNT_EN to build in the rejected-bounce counter.
module alarm_switch_conditioner
  import alarm_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned GLITCH_W        = GLITCH_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sw_raw,
  output logic                sw_clean,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt,
  input  logic                glitch_clr
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sw_sync;
  sw_state_t        state;
  logic [CNT_W-1:0] cnt;

  alarm_sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sw_raw),
    .q       (sw_sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      sw_clean   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sw_sync) begin
            state <= PEND_HI;
            cnt   <= '0;
          end
        end
        PEND_HI: begin
          if (!sw_sync) begin
            state <= STABLE_LO;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_HI;
            sw_clean   <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!sw_sync) begin
            state <= PEND_LO;
            cnt   <= '0;
          end
        end
        PEND_LO: begin
          if (sw_sync) begin
            state <= STABLE_HI;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_LO;
            sw_clean   <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= STABLE_LO;
      endcase
    end
  end

`ifdef ALARM_SW_GLITCH_CNT_EN
  // A glitch is a pending state seeing the old level again on this edge.
  logic glitch_evt;
  assign glitch_evt = ((state == PEND_HI) && !sw_sync) ||
                      ((state == PEND_LO) &&  sw_sync);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_evt && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`else
  logic unused_glitch_clr;
  assign unused_glitch_clr = glitch_clr;
  assign glitch_cnt        = '0;
`endif

endmodule

// File: tb/tb_alarm_switch_conditioner.sv
// Directed self-checking bench for alarm_switch_conditioner (DEBOUNCE_CYCLES=4, GLITCH_W=4).
module tb_alarm_switch_conditioner;

`ifdef ALARM_SW_GLITCH_CNT_EN
  localparam bit GON = 1'b1;
`else
  localparam bit GON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sw_raw;
  logic       glitch_clr;
  logic       sw_clean;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [3:0] glitch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       raw;
    logic       clr;
    logic       clean;
    logic       rise;
    logic       fall;
    logic [3:0] gcnt;
  } vec_t;

  vec_t tbl[23];

  alarm_switch_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .GLITCH_W        (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .glitch_cnt (glitch_cnt),
    .glitch_clr (glitch_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] eg(input int unsigned v);
    return GON ? 4'(v) : 4'd0;
  endfunction

  function automatic vec_t mk(input logic raw, input logic clr, input logic clean,
                              input logic rise, input logic fall, input logic [3:0] g);
    vec_t v;
    v.raw = raw; v.clr = clr; v.clean = clean; v.rise = rise; v.fall = fall; v.gcnt = g;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic c, input logic r,
                       input logic f, input logic [3:0] g);
    n_cmp++;
    if ({sw_clean, rise_pulse, fall_pulse, glitch_cnt} !== {c, r, f, g}) begin
      n_err++;
      $display("FAIL %s: got clean=%0b rise=%0b fall=%0b gcnt=%0d, want clean=%0b rise=%0b fall=%0b gcnt=%0d",
               name, sw_clean, rise_pulse, fall_pulse, glitch_cnt, c, r, f, g);
    end
  endtask

  // raw high for two sampled cycles then low long enough for the FSM to settle back
  task automatic bounce(input logic clr_on_evt);
    sw_raw = 1'b1; tick();
    tick();
    sw_raw = 1'b0; tick();
    tick();
    glitch_clr = clr_on_evt; tick();
    glitch_clr = 1'b0; tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    sw_raw     = 1'b0;
    glitch_clr = 1'b0;

    // press: raw sampled high on row 0, clean rises six edges later
    for (int i = 0; i < 6; i++) tbl[i] = mk(1, 0, 0, 0, 0, 0);
    tbl[6] = mk(1, 0, 1, 1, 0, 0);
    tbl[7] = mk(1, 0, 1, 0, 0, 0);
    // release
    for (int i = 8; i < 14; i++) tbl[i] = mk(0, 0, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0);
    // bounce: two high samples, rejected on the fourth edge after the first
    tbl[16] = mk(1, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0);
    for (int i = 20; i < 23; i++) tbl[i] = mk(0, 0, 0, 0, 0, eg(1));

    repeat (3) tick();
    check("reset_state", 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_after_reset", 0, 0, 0, 0);
    end

    for (int i = 0; i < 23; i++) begin
      sw_raw     = tbl[i].raw;
      glitch_clr = tbl[i].clr;
      tick();
      check($sformatf("vec%0d", i), tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].gcnt);
    end

    // saturation: 20 more bounces on top of the one already counted
    for (int k = 1; k <= 20; k++) begin
      bounce(1'b0);
      check($sformatf("sat_bounce%0d", k), 0, 0, 0, eg((k + 1 > 15) ? 15 : k + 1));
    end

    // clear arriving on the same edge as a glitch increment wins
    bounce(1'b1);
    check("clr_vs_incr", 0, 0, 0, 0);

    // reset while pending high with counter at 2
    bounce(1'b0);
    check("pre_reset_glitch", 0, 0, 0, eg(1));
    sw_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pend_before_reset", 0, 0, 0, eg(1));
    end
    reset_n = 1'b0;
    #1;
    check("reset_mid_pend", 0, 0, 0, 0);
    tick();
    tick();
    check("reset_held", 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_reset%0d", i), 0, 0, 0, 0);
    end
    tick();
    check("post_reset_rise", 1, 1, 0, 0);
    tick();
    check("post_reset_hold", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_switch_conditioner.md
ALARM_SWITCH_CONDITIONER -- requirements
Module: alarm_switch_conditioner

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 50000, stable-sample count required to accept a new level (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter: GLITCH_W, 8, width of rejected-bounce counter.
REQ-003 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: sw_raw  input  1  unsynchronised alarm switch pin, may bounce.
REQ-006 SHALL have port: sw_clean  output  1  debounced level; drives the alarm PIO in_port.
REQ-007 SHALL have port: rise_pulse  output  1  one-cycle strobe when sw_clean goes 0->1.
REQ-008 SHALL have port: fall_pulse  output  1  one-cycle strobe when sw_clean goes 1->0.
REQ-009 SHALL have port: glitch_cnt  output  GLITCH_W  count of rejected pending transitions.
REQ-010 SHALL have port: glitch_clr  input  1  synchronous clear of glitch_cnt.

Function
REQ-011 SHALL synchronise sw_raw through exactly two flops to form sw_sync; no other logic sees sw_raw.
REQ-012 SHALL run FSM with states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-013 SHALL move STABLE_LO->PEND_HI (STABLE_HI->PEND_LO) when sw_sync differs from sw_clean, loading counter to 0.
REQ-014 SHALL, in PEND_*, increment counter each cycle sw_sync holds the new level; counter width = clog2(DEBOUNCE_CYCLES).
REQ-015 SHALL, in PEND_* with counter == DEBOUNCE_CYCLES-1 and sw_sync at new level, enter STABLE_* and update sw_clean on that edge.
REQ-016 SHALL, in PEND_* when sw_sync returns to the old level, return to STABLE_* of old level, leave sw_clean unchanged, and increment glitch_cnt.
REQ-017 SHALL give latency: sw_raw sampled stable at edge k -> sw_clean changes at edge k+DEBOUNCE_CYCLES+2.
REQ-018 SHALL assert rise_pulse/fall_pulse for exactly the one cycle following the sw_clean change; never both; never on glitch.
REQ-019 SHALL register all outputs; no combinational path input->output.
REQ-020 SHALL saturate glitch_cnt at all-ones (no wrap).
REQ-021 SHALL give glitch_clr priority over a simultaneous increment (result 0).

Reset
REQ-022 SHALL, on reset_n low, force sync flops 0, state STABLE_LO, counter 0, sw_clean 0, rise_pulse 0, fall_pulse 0, glitch_cnt 0.
REQ-023 SHALL discard any pending transition on reset mid-operation; no pulse emitted on reset exit.
REQ-024 SHALL, if sw_raw is 1 at reset release, qualify it as a normal rising transition (rise_pulse after full latency).

Configuration
REQ-025 SHALL compile glitch counting in only when ALARM_SW_GLITCH_CNT_EN is defined.
REQ-026 SHALL, without ALARM_SW_GLITCH_CNT_EN, tie glitch_cnt to 0, ignore glitch_clr, and keep all other behaviour identical.

Structure
REQ-027 SHALL place FSM state enum and default DEBOUNCE_CYCLES/GLITCH_W constants in shared package alarm_cond_pkg.
REQ-028 SHALL implement the two-flop synchroniser as sub-module alarm_sync_2ff (reset value 0), reusable for other alarm inputs.

Verification (DEBOUNCE_CYCLES=4, GLITCH_W=4, ALARM_SW_GLITCH_CNT_EN defined)
REQ-029 SHALL cover clean press: sw_raw 0->1 sampled at edge 10 and held -> sw_clean=1 at edge 16, rise_pulse high cycle 16-17 only.
REQ-030 SHALL cover bounce: sw_raw high for 2 cycles then low -> sw_clean stays 0, no pulse, glitch_cnt=1.
REQ-031 SHALL cover release: from sw_clean=1, sw_raw 1->0 held -> sw_clean=0 after 6 edges, single fall_pulse.
REQ-032 SHALL cover saturation/clear: 20 bounces -> glitch_cnt=15; glitch_clr coincident with a bounce -> glitch_cnt=0.
REQ-033 SHALL cover reset mid-PEND_HI: reset_n low at counter=2 -> all outputs 0, no rise_pulse; with sw_raw held 1 after release, rise_pulse after full latency.
REQ-034 SHALL cover macro off: rebuild without ALARM_SW_GLITCH_CNT_EN, rerun REQ-030 -> glitch_cnt=0, sw_clean trace identical.
